// File: rtl/sram_pkg.sv
// Shared types and elaboration helpers for the maskable single-port SRAM model.
package sram_pkg;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  // Smallest address width able to index 'depth' words (never below 1).
  function automatic int min_addr_width(input int depth);
    for (int w = 1; w < 32; w++)
      if ((1 << w) >= depth) return w;
    return 32;
  endfunction

endpackage

// File: rtl/sram_out_stage.sv
// Optional read-data output register: loads on valid, otherwise holds data and drops valid.
module sram_out_stage #(
  parameter int Bits = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [Bits-1:0] d,
  input  logic            vld_in,
  output logic [Bits-1:0] q,
  output logic            vld
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q   <= '0;
      vld <= 1'b0;
    end else begin
      vld <= vld_in;
      if (vld_in) q <= d;
    end
  end

endmodule

// File: rtl/sram_1p_bwm.sv
// Parametrised single-port SRAM model with per-bit write mask, init sweep after
// reset, read-valid strobe and an optional extra output register.
module sram_1p_bwm
  import sram_pkg::*;
#(
  parameter int              Bits          = 64,
  parameter int              Word_Depth    = 512,
  parameter int              Add_Width     = 9,
  parameter int              Out_Reg       = 0,
  parameter int              Init_On_Reset = 1,
  parameter logic [Bits-1:0] Init_Val      = '0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 CEB,
  input  logic                 WEB,
  input  logic [Add_Width-1:0] A,
  input  logic [Bits-1:0]      D,
  input  logic [Bits-1:0]      BWEB,
  output logic [Bits-1:0]      Q,
  output logic                 RVALID,
  output logic                 READY
);

  localparam logic [Add_Width:0]   DEPTH = (Add_Width+1)'(Word_Depth);
  localparam logic [Add_Width-1:0] LAST  = Add_Width'(Word_Depth - 1);

  if (Add_Width < min_addr_width(Word_Depth)) begin : g_bad_aw
    $error("sram_1p_bwm: Add_Width too small for Word_Depth");
  end
  if (Bits < 1) begin : g_bad_bits
    $error("sram_1p_bwm: Bits must be at least 1");
  end

  logic [Bits-1:0]      ram [Word_Depth];
  state_t               state;
  logic [Add_Width-1:0] cnt;
  logic                 ready_r;
  logic [Bits-1:0]      q1;
  logic                 v1;
  logic                 run;
  logic                 in_range;
  logic                 wr_en;

  assign run      = (state == ST_RUN);
  assign in_range = ({1'b0, A} < DEPTH);
  // An X on CEB makes wr_en X, which the 'if' treats as false: array untouched.
  assign wr_en    = run && (CEB == 1'b0) && (WEB == 1'b0) && in_range;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= ST_INIT;
      cnt     <= '0;
      ready_r <= 1'b0;
    end else if (state == ST_INIT) begin
      if (Init_On_Reset == 0 || cnt == LAST) begin
        state   <= ST_RUN;
        ready_r <= 1'b1;
      end
      cnt <= cnt + 1'b1;
    end
  end

  // Array has no reset; the sweep owns the write port until ST_RUN.
  always_ff @(posedge CLK) begin
    if (state == ST_INIT && Init_On_Reset != 0)
      ram[cnt] <= Init_Val;
    else if (wr_en)
      ram[A] <= (ram[A] & BWEB) | (D & ~BWEB);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q1 <= '0;
      v1 <= 1'b0;
    end else if (!run) begin
      v1 <= 1'b0;
    end else if (CEB == 1'b1) begin
      v1 <= 1'b0;
    end else if (CEB == 1'b0) begin
      v1 <= WEB;
      if (WEB) q1 <= in_range ? ram[A] : '0;
    end else begin
      q1 <= 'x;
      v1 <= 1'b0;
    end
  end

  if (Out_Reg != 0) begin : g_oreg
    sram_out_stage #(.Bits(Bits)) u_out (
      .clk    (CLK),
      .rst    (RST),
      .d      (q1),
      .vld_in (v1),
      .q      (Q),
      .vld    (RVALID)
    );
  end else begin : g_direct
    assign Q      = q1;
    assign RVALID = v1;
  end

  assign READY = ready_r;

endmodule

// File: tb/tb_sram_1p_bwm.sv
// Directed bench: three instances (depth 8 latency 1, depth 8 latency 2, depth 6)
// share one stimulus stream; expected values come from hand-built vectors.
module tb_sram_1p_bwm;

  logic        CLK;
  logic        RST;
  logic        CEB;
  logic        WEB;
  logic [2:0]  A;
  logic [63:0] D;
  logic [63:0] BWEB;
  logic [63:0] q0, q1, q2;
  logic        rv0, rv1, rv2;
  logic        rdy0, rdy1, rdy2;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] IV  = 64'hA5;
  localparam logic [63:0] M   = 64'h0000_0000_FFFF_FFFF;
  localparam logic [63:0] F   = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] N0  = 64'h1030_5070_90B0_D0F5;
  localparam logic [63:0] N2  = 64'h1030_5070_90B0_D0F0;
  localparam logic [63:0] HI  = 64'hFFFF_FFFF_0000_0000;
  localparam logic [63:0] NIB = 64'h0F0F_0F0F_0F0F_0F0F;
  localparam logic [63:0] DW  = 64'h1234_5678_9ABC_DEF0;

  sram_1p_bwm #(.Bits(64), .Word_Depth(8), .Add_Width(3), .Out_Reg(0),
                .Init_On_Reset(1), .Init_Val(IV)) u0 (
    .CLK(CLK), .RST(RST), .CEB(CEB), .WEB(WEB), .A(A), .D(D), .BWEB(BWEB),
    .Q(q0), .RVALID(rv0), .READY(rdy0));

  sram_1p_bwm #(.Bits(64), .Word_Depth(8), .Add_Width(3), .Out_Reg(1),
                .Init_On_Reset(1), .Init_Val(IV)) u1 (
    .CLK(CLK), .RST(RST), .CEB(CEB), .WEB(WEB), .A(A), .D(D), .BWEB(BWEB),
    .Q(q1), .RVALID(rv1), .READY(rdy1));

  sram_1p_bwm #(.Bits(64), .Word_Depth(6), .Add_Width(3), .Out_Reg(0),
                .Init_On_Reset(1), .Init_Val(64'h0)) u2 (
    .CLK(CLK), .RST(RST), .CEB(CEB), .WEB(WEB), .A(A), .D(D), .BWEB(BWEB),
    .Q(q2), .RVALID(rv2), .READY(rdy2));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        ceb;
    logic        web;
    logic [2:0]  a;
    logic [63:0] d;
    logic [63:0] bweb;
    logic [63:0] q0;
    logic        v0;
    logic [63:0] q2;
    logic        v2;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic ceb, input logic web, input logic [2:0] a,
                     input logic [63:0] d, input logic [63:0] bweb,
                     input logic [63:0] eq0, input logic ev0,
                     input logic [63:0] eq2, input logic ev2);
    vec_t v;
    v.ceb = ceb; v.web = web; v.a = a; v.d = d; v.bweb = bweb;
    v.q0 = eq0; v.v0 = ev0; v.q2 = eq2; v.v2 = ev2;
    vt.push_back(v);
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ceb, input logic web, input logic [2:0] a,
                       input logic [63:0] d, input logic [63:0] bweb);
    CEB = ceb; WEB = web; A = a; D = d; BWEB = bweb;
  endtask

  initial begin
    logic [63:0] pq;
    logic        pv;

    // Vector table (runs after the first init sweep)
    for (int i = 0; i < 8; i++)
      add(1'b0, 1'b1, 3'(i), '0, F, IV, 1'b1, 64'h0, 1'b1);
    add(1'b0, 1'b0, 3'd3, F,  HI,  IV, 1'b0, 64'h0, 1'b0);
    add(1'b0, 1'b1, 3'd3, '0, F,   M,  1'b1, M,     1'b1);
    add(1'b0, 1'b0, 3'd4, DW, NIB, M,  1'b0, M,     1'b0);
    add(1'b1, 1'b1, 3'd4, '0, F,   M,  1'b0, M,     1'b0);
    add(1'b0, 1'b1, 3'd4, '0, F,   N0, 1'b1, N2,    1'b1);
    add(1'b0, 1'b0, 3'd5, F,  F,   N0, 1'b0, N2,    1'b0);
    add(1'b0, 1'b1, 3'd5, '0, F,   IV, 1'b1, 64'h0, 1'b1);
    add(1'b0, 1'b0, 3'd7, F,  '0,  IV, 1'b0, 64'h0, 1'b0);
    add(1'b0, 1'b0, 3'd6, F,  '0,  IV, 1'b0, 64'h0, 1'b0);
    add(1'b0, 1'b1, 3'd7, '0, F,   F,  1'b1, 64'h0, 1'b1);
    add(1'b0, 1'b1, 3'd6, '0, F,   F,  1'b1, 64'h0, 1'b1);
    add(1'b0, 1'b1, 3'd0, '0, F,   IV, 1'b1, 64'h0, 1'b1);
    add(1'b0, 1'b1, 3'd2, '0, F,   IV, 1'b1, 64'h0, 1'b1);
    add(1'b0, 1'b1, 3'd5, '0, F,   IV, 1'b1, 64'h0, 1'b1);
    add(1'b0, 1'b1, 3'd3, '0, F,   M,  1'b1, M,     1'b1);
    add(1'b0, 1'b1, 3'd4, '0, F,   N0, 1'b1, N2,    1'b1);

    // Reset state
    RST = 1'b1;
    drive(1'b1, 1'b1, 3'd0, '0, F);
    cyc(); cyc();
    chk("rst q0", q0, '0);   chk("rst rv0", 64'(rv0), 0);  chk("rst rdy0", 64'(rdy0), 0);
    chk("rst q1", q1, '0);   chk("rst rv1", 64'(rv1), 0);  chk("rst rdy1", 64'(rdy1), 0);
    chk("rst q2", q2, '0);   chk("rst rdy2", 64'(rdy2), 0);

    // Init sweep with requests that must be ignored
    drive(1'b0, 1'b0, 3'd2, 64'h1, '0);
    RST = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk($sformatf("init%0d rdy0", k), 64'(rdy0), 64'(k >= 8));
      chk($sformatf("init%0d rdy1", k), 64'(rdy1), 64'(k >= 8));
      chk($sformatf("init%0d rdy2", k), 64'(rdy2), 64'(k >= 6));
      chk($sformatf("init%0d rv0", k), 64'(rv0), 0);
      chk($sformatf("init%0d rv1", k), 64'(rv1), 0);
      chk($sformatf("init%0d rv2", k), 64'(rv2), 0);
      chk($sformatf("init%0d q0", k), q0, '0);
      if (k == 3) drive(1'b0, 1'b1, 3'd2, '0, F);
      if (k == 5) drive(1'b1, 1'b1, 3'd0, '0, F);
    end

    // Table-driven; the latency-2 instance lags the latency-1 one by one vector
    pq = '0;
    pv = 1'b0;
    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].ceb, vt[i].web, vt[i].a, vt[i].d, vt[i].bweb);
      cyc();
      chk($sformatf("vec%0d q0", i), q0, vt[i].q0);
      chk($sformatf("vec%0d rv0", i), 64'(rv0), 64'(vt[i].v0));
      chk($sformatf("vec%0d q2", i), q2, vt[i].q2);
      chk($sformatf("vec%0d rv2", i), 64'(rv2), 64'(vt[i].v2));
      chk($sformatf("vec%0d q1", i), q1, pq);
      chk($sformatf("vec%0d rv1", i), 64'(rv1), 64'(pv));
      pq = vt[i].q0;
      pv = vt[i].v0;
    end

    // Out_Reg latency and hold
    drive(1'b0, 1'b1, 3'd3, '0, F);
    cyc();
    chk("lat flush q1", q1, N0); chk("lat flush rv1", 64'(rv1), 1);
    drive(1'b1, 1'b1, 3'd0, '0, F);
    cyc();
    chk("lat a3 q1", q1, M); chk("lat a3 rv1", 64'(rv1), 1);
    cyc();
    chk("lat idle q1", q1, M); chk("lat idle rv1", 64'(rv1), 0);
    drive(1'b0, 1'b1, 3'd5, '0, F);
    cyc();
    chk("lat e1 q1", q1, M); chk("lat e1 rv1", 64'(rv1), 0);
    drive(1'b1, 1'b1, 3'd0, '0, F);
    cyc();
    chk("lat e2 q1", q1, IV); chk("lat e2 rv1", 64'(rv1), 1);
    for (int k = 3; k <= 5; k++) begin
      cyc();
      chk($sformatf("hold%0d q1", k), q1, IV);
      chk($sformatf("hold%0d rv1", k), 64'(rv1), 0);
    end

    // Reset with a read in flight in the output stage
    drive(1'b0, 1'b1, 3'd3, '0, F);
    cyc();
    chk("pre-rst q0", q0, M); chk("pre-rst rv0", 64'(rv0), 1);
    chk("pre-rst rv1", 64'(rv1), 0);
    RST = 1'b1;
    #1;
    chk("async q0", q0, '0); chk("async rv0", 64'(rv0), 0); chk("async rdy0", 64'(rdy0), 0);
    chk("async q1", q1, '0); chk("async rv1", 64'(rv1), 0);
    cyc();
    RST = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      chk($sformatf("sweepA%0d rv1", k), 64'(rv1), 0);
      chk($sformatf("sweepA%0d rdy0", k), 64'(rdy0), 0);
    end

    // Reset again with the sweep at cnt=4: sweep restarts from word 0
    RST = 1'b1;
    #1;
    chk("mid rdy0", 64'(rdy0), 0); chk("mid q1", q1, '0);
    cyc();
    RST = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk($sformatf("sweepB%0d rdy0", k), 64'(rdy0), 64'(k >= 8));
      chk($sformatf("sweepB%0d rdy1", k), 64'(rdy1), 64'(k >= 8));
      chk($sformatf("sweepB%0d rv0", k), 64'(rv0), 0);
      chk($sformatf("sweepB%0d rv1", k), 64'(rv1), 0);
    end

    // Word 3 must be back to the init value after the re-sweep
    cyc();
    chk("reinit q0", q0, IV); chk("reinit rv0", 64'(rv0), 1);
    chk("reinit q2", q2, '0); chk("reinit rv2", 64'(rv2), 1);
    drive(1'b1, 1'b1, 3'd0, '0, F);
    cyc();
    chk("reinit q1", q1, IV); chk("reinit rv1", 64'(rv1), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_1p_bwm.md
Name: sram_1p_bwm

Overview:
Parametrised single-port synchronous SRAM behavioural model, the successor to the fixed 512x64 macro model. It adds a per-bit write mask, an optional extra output register stage, and a read-valid strobe. Non-read cycles hold the last read data instead of producing random data. After reset, a hardware initialisation sweep writes a known value to every word. It sits under cache data/tag arrays and other on-chip buffers wherever a deterministic, maskable macro model is needed for simulation.

Parameters:
Bits, 64, data word width in bits (>=1)
Word_Depth, 512, number of words (need not be a power of 2)
Add_Width, 9, address width; must satisfy 2**Add_Width >= Word_Depth
Out_Reg, 0, 0 = read latency 1; 1 = extra output flop, read latency 2
Init_On_Reset, 1, 1 = run init sweep after reset; 0 = usable immediately
Init_Val, 0, Bits-wide value written to every word by the sweep

Ports:
CLK  input  1  clock, all state updates on rising edge
RST  input  1  reset, asynchronous, active-high
CEB  input  1  chip enable, active-low
WEB  input  1  write enable, active-low (0 = write, 1 = read when CEB=0)
A    input  Add_Width  word address
D    input  Bits  write data
BWEB input  Bits  per-bit write enable, active-low (bit i written when BWEB[i]=0)
Q    output Bits  read data
RVALID output 1  high for one cycle when Q presents new read data
READY output 1  high when the array accepts requests (init complete)

Behaviour:
- Reset (RST=1, async): Q=0, RVALID=0, READY=0, output-stage flop and its valid cleared, state=ST_INIT, init counter=0. The array itself is not cleared asynchronously.
- Reset release with Init_On_Reset=1: ST_INIT writes Init_Val to ram[cnt] on each edge and increments cnt, from 0 to Word_Depth-1 (Word_Depth cycles). On the edge that writes Word_Depth-1, the block enters ST_RUN and READY goes to 1.
- Reset release with Init_On_Reset=0: the first edge after release moves the block to ST_RUN with READY=1. Array contents are undefined (X).
- In ST_INIT, CEB/WEB/A/D/BWEB are ignored: no user write, no read, RVALID=0, Q holds 0.
- Write (ST_RUN, CEB=0, WEB=0, A<Word_Depth): at the edge, ram[A][i] <= D[i] for every i with BWEB[i]=0. Other bits are unchanged. BWEB all-ones means no change. Q and RVALID are unaffected.
- Read (ST_RUN, CEB=0, WEB=1): array output is sampled at the edge.
  - Out_Reg=0: Q=ram[A] and RVALID=1 after that edge.
  - Out_Reg=1: the same values appear one edge later.
- Back-to-back reads produce one RVALID per cycle at full throughput.
- Write then read of the same address on the next cycle returns the written (masked-merged) data.
- Idle (CEB=1) or write cycle: Q holds its last value and RVALID=0 (each output stage holds independently).
- Out-of-range address (A>=Word_Depth): writes are dropped; reads return all-zero data with RVALID=1.
- Reset mid-sweep or mid-read: outputs clear immediately and the sweep restarts from word 0. A pending read in the Out_Reg stage is discarded (no RVALID after reset).
- Single-port: a read and a write cannot coincide. WEB selects the operation.
- Simulation aid: an X on CEB in ST_RUN drives Q to all-X on the next edge and leaves the array unmodified.

Decomposition:
- Package sram_pkg: state enum {ST_INIT, ST_RUN} and a localparam function computing the minimum address width from depth (used in an elaboration-time check that Add_Width is sufficient).
- One natural sub-module: sram_out_stage (Bits-wide data plus valid flop with async reset and hold-when-no-valid). It is instantiated only when Out_Reg=1 via generate.
- The array, the write-mask merge, the init counter and the FSM stay in the top module.

Test Plan:
- Init sweep: Word_Depth=8, Init_Val=64'hA5, release RST -> READY rises after exactly 8 edges; reads of A=0..7 each return 64'hA5 with RVALID one cycle later.
- Masked write: write D=64'hFFFF_FFFF_FFFF_FFFF, BWEB=64'hFFFF_FFFF_0000_0000 to A=3 (preloaded 0), read A=3 -> Q=64'h0000_0000_FFFF_FFFF.
- Latency and hold: Out_Reg=1, read A=5 then CEB=1 for 3 cycles -> RVALID high only on the 2nd edge after the request; Q stays at ram[5] for the next 3 cycles.
- Requests during init: issue a write to A=2 (D=1) while READY=0 -> after init, read A=2 returns Init_Val; RVALID=0 throughout init.
- Reset mid-operation: assert RST with a read in flight (Out_Reg=1) and the sweep at cnt=4 -> Q=0 and RVALID=0 immediately; no RVALID after release; READY returns after a full Word_Depth cycles.
- Out of range: Word_Depth=6, Add_Width=3, write A=7 then read A=7 -> Q=0 with RVALID=1; words 0..5 unchanged.
